// File: rtl/display_label_sequencer_if.sv
// display_label_sequencer_if: tick/value/mask inputs and the decoder-facing outputs of the sequencer.
interface display_label_sequencer_if #(
    parameter int CHANNELS = 2,
    parameter int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
    logic                  tick_i;
    logic [4*CHANNELS-1:0] values_i;
    logic [CHANNELS-1:0]   mask_i;
    logic                  hold_i;
    logic                  value_only_i;
    logic [3:0]            code_o;
    logic [CW-1:0]         channel_o;
    logic                  is_label_o;
    logic                  blank_o;
    modport master (
        output tick_i, values_i, mask_i, hold_i, value_only_i,
        input  code_o, channel_o, is_label_o, blank_o
    );
    modport slave (
        input  tick_i, values_i, mask_i, hold_i, value_only_i,
        output code_o, channel_o, is_label_o, blank_o
    );
endinterface

// File: rtl/display_label_sequencer.sv
// display_label_sequencer: steps through enabled channels showing a label code then a latched value,
// each for DWELL tick pulses, driving one 7-segment digit decoder.
module display_label_sequencer #(
    parameter int          CHANNELS   = 2,
    parameter int          DWELL      = 4,
    parameter logic [3:0]  LABEL_BASE = 4'hA,
    parameter int          CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input logic clk_i,
    input logic rst_i,
    display_label_sequencer_if.slave bus
);
    localparam int CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;
    typedef enum logic [1:0] {IDLE, BLANK, LABEL, VALUE} state_e;
    state_e         state_q, state_d;
    logic [CW-1:0]   ch_q, ch_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [3:0]      latch_q, latch_d, code_q, code_d;
    logic            is_label_q, blank_q, armed_q;
    logic            any_en, last_tick, enter;
    // Next enabled channel strictly after `from`, wrapping; `from` itself is the last candidate.
    function automatic logic [CW-1:0] next_en(input logic [CHANNELS-1:0] m, input logic [CW-1:0] from);
        logic [CW-1:0] r;
        int idx;
        r = from;
        for (int k = CHANNELS; k >= 1; k--) begin
            idx = (int'(from) + k) % CHANNELS;
            if (m[idx]) r = CW'(idx);
        end
        return r;
    endfunction
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        cnt_d     = cnt_q;
        enter     = 1'b0;
        any_en    = |bus.mask_i;
        last_tick = cnt_q == CNTW'(DWELL - 1);
        case (state_q)
            IDLE, BLANK: begin
                // IDLE lingers for one edge after reset release before picking a channel.
                if (state_q == BLANK || armed_q) begin
                    state_d = !any_en ? BLANK : bus.value_only_i ? VALUE : LABEL;
                    ch_d    = any_en ? next_en(bus.mask_i, CW'(CHANNELS - 1)) : ch_q;
                    cnt_d   = '0;
                    enter   = any_en;
                end
            end
            default: begin
                if (!bus.mask_i[ch_q]) begin
                    state_d = !any_en ? BLANK : bus.value_only_i ? VALUE : LABEL;
                    ch_d    = any_en ? next_en(bus.mask_i, ch_q) : ch_q;
                    cnt_d   = '0;
                    enter   = any_en;
                end else if (!bus.hold_i && bus.tick_i) begin
                    cnt_d = last_tick ? '0 : cnt_q + 1'b1;
                    enter = last_tick;
                    if (last_tick && state_q == LABEL) state_d = VALUE;
                    else if (last_tick) begin
                        ch_d    = next_en(bus.mask_i, ch_q);
                        state_d = bus.value_only_i ? VALUE : LABEL;
                    end
                end
            end
        endcase
        latch_d = (enter && state_d == VALUE) ? bus.values_i[{ch_d, 2'b00} +: 4] : latch_q;
        code_d  = state_d == LABEL ? LABEL_BASE + 4'(ch_d) : state_d == VALUE ? latch_d : 4'hF;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            ch_q       <= '0;
            cnt_q      <= '0;
            latch_q    <= '0;
            code_q     <= 4'hF;
            is_label_q <= 1'b0;
            blank_q    <= 1'b1;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            cnt_q      <= cnt_d;
            latch_q    <= latch_d;
            code_q     <= code_d;
            is_label_q <= state_d == LABEL;
            blank_q    <= state_d == IDLE || state_d == BLANK;
            armed_q    <= 1'b1;
        end
    end
    assign bus.code_o     = code_q;
    assign bus.channel_o  = ch_q;
    assign bus.is_label_o = is_label_q;
    assign bus.blank_o    = blank_q;
endmodule

// File: tb/tb_display_label_sequencer.sv
// tb_display_label_sequencer: directed steps push expected outputs per edge; a negedge monitor pops and checks them.
module tb_display_label_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    display_label_sequencer_if #(.CHANNELS(2)) ifa ();
    display_label_sequencer_if #(.CHANNELS(5)) ifb ();
    display_label_sequencer #(.CHANNELS(2), .DWELL(4), .LABEL_BASE(4'hA)) dut_a (.clk_i(clk), .rst_i(rst), .bus(ifa));
    display_label_sequencer #(.CHANNELS(5), .DWELL(2), .LABEL_BASE(4'hA)) dut_b (.clk_i(clk), .rst_i(rst), .bus(ifb));
    typedef struct {
        bit         sel;
        logic [3:0] code;
        int         ch;
        logic       isl;
        logic       blk;
        int         id;
    } exp_t;
    exp_t q[$];
    exp_t cur;
    int checks = 0;
    int failures = 0;
    int steps = 0;
    task automatic chk(input string tag, input int id, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s step=%0d got=%0h want=%0h", tag, id, obs, exp);
        end
    endtask
    // ch < 0 marks the channel as don't-care for that step.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            cur = q.pop_front();
            if (!cur.sel) begin
                chk("code", cur.id, 32'(ifa.code_o), 32'(cur.code));
                if (cur.ch >= 0) chk("channel", cur.id, 32'(ifa.channel_o), cur.ch);
                chk("is_label", cur.id, 32'(ifa.is_label_o), 32'(cur.isl));
                chk("blank", cur.id, 32'(ifa.blank_o), 32'(cur.blk));
            end else begin
                chk("b_code", cur.id, 32'(ifb.code_o), 32'(cur.code));
                if (cur.ch >= 0) chk("b_channel", cur.id, 32'(ifb.channel_o), cur.ch);
                chk("b_is_label", cur.id, 32'(ifb.is_label_o), 32'(cur.isl));
                chk("b_blank", cur.id, 32'(ifb.blank_o), 32'(cur.blk));
            end
        end
    end
    task automatic run(input bit sel, input int n, input logic [3:0] code, input int ch, input logic isl, input logic blk);
        repeat (n) begin
            @(posedge clk);
            #1;
            steps++;
            q.push_back('{sel, code, ch, isl, blk, steps});
        end
    endtask
    initial begin
        rst = 1'b1;
        ifa.tick_i = 1'b1;
        ifa.values_i = 8'h73;
        ifa.mask_i = 2'b11;
        ifa.hold_i = 1'b0;
        ifa.value_only_i = 1'b0;
        ifb.tick_i = 1'b1;
        ifb.values_i = 20'h56781;
        ifb.mask_i = 5'b10001;
        ifb.hold_i = 1'b0;
        ifb.value_only_i = 1'b0;
        // reset and two-edge release latency
        run(0, 2, 4'hF, 0, 0, 1);
        rst = 1'b0;
        run(0, 1, 4'hF, 0, 0, 1);
        run(0, 4, 4'hA, 0, 1, 0);
        run(0, 4, 4'h3, 0, 0, 0);
        run(0, 4, 4'hB, 1, 1, 0);
        run(0, 4, 4'h7, 1, 0, 0);
        run(0, 4, 4'hA, 0, 1, 0);
        // mask drop of channel 0 mid-label
        ifa.mask_i = 2'b10;
        run(0, 4, 4'hB, 1, 1, 0);
        run(0, 4, 4'h7, 1, 0, 0);
        run(0, 4, 4'hB, 1, 1, 0);
        run(0, 2, 4'h7, 1, 0, 0);
        ifa.mask_i = 2'b00;
        run(0, 3, 4'hF, -1, 0, 1);
        ifa.mask_i = 2'b01;
        run(0, 4, 4'hA, 0, 1, 0);
        run(0, 2, 4'h3, 0, 0, 0);
        // value change mid-phase stays hidden until the next visit
        ifa.values_i = 8'h79;
        run(0, 2, 4'h3, 0, 0, 0);
        run(0, 4, 4'hA, 0, 1, 0);
        run(0, 4, 4'h9, 0, 0, 0);
        run(0, 2, 4'hA, 0, 1, 0);
        // hold for 10 cycles mid-label
        ifa.hold_i = 1'b1;
        run(0, 10, 4'hA, 0, 1, 0);
        ifa.hold_i = 1'b0;
        run(0, 2, 4'hA, 0, 1, 0);
        run(0, 1, 4'h9, 0, 0, 0);
        // value-only mode over both channels
        ifa.values_i = 8'h73;
        ifa.value_only_i = 1'b1;
        ifa.mask_i = 2'b11;
        run(0, 3, 4'h9, 0, 0, 0);
        run(0, 4, 4'h7, 1, 0, 0);
        run(0, 4, 4'h3, 0, 0, 0);
        run(0, 2, 4'h7, 1, 0, 0);
        // reset mid-phase
        rst = 1'b1;
        run(0, 1, 4'hF, 0, 0, 1);
        rst = 1'b0;
        run(0, 1, 4'hF, 0, 0, 1);
        run(0, 4, 4'h3, 0, 0, 0);
        run(0, 1, 4'h7, 1, 0, 0);
        ifa.value_only_i = 1'b0;
        run(0, 3, 4'h7, 1, 0, 0);
        run(0, 2, 4'hA, 0, 1, 0);
        // value-only rising mid-label lets the label finish
        ifa.value_only_i = 1'b1;
        run(0, 2, 4'hA, 0, 1, 0);
        run(0, 4, 4'h3, 0, 0, 0);
        run(0, 4, 4'h7, 1, 0, 0);
        // mask drop honoured during hold, then single-channel re-latch
        ifa.hold_i = 1'b1;
        run(0, 3, 4'h7, 1, 0, 0);
        ifa.mask_i = 2'b01;
        run(0, 1, 4'h3, 0, 0, 0);
        run(0, 3, 4'h3, 0, 0, 0);
        ifa.values_i = 8'h74;
        ifa.hold_i = 1'b0;
        run(0, 3, 4'h3, 0, 0, 0);
        run(0, 1, 4'h4, 0, 0, 0);
        // five channels, mask 10001, wrap from 4 back to 0
        rst = 1'b1;
        run(1, 1, 4'hF, 0, 0, 1);
        rst = 1'b0;
        run(1, 1, 4'hF, 0, 0, 1);
        run(1, 2, 4'hA, 0, 1, 0);
        run(1, 2, 4'h1, 0, 0, 0);
        run(1, 2, 4'hE, 4, 1, 0);
        run(1, 2, 4'h5, 4, 0, 0);
        run(1, 2, 4'hA, 0, 1, 0);
        run(1, 2, 4'h1, 0, 0, 0);
        @(negedge clk);
        #1;
        checks++;
        assert (q.size() == 0) else begin
            failures++;
            $error("FAIL drain left=%0d want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
